// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and its HI/LO pair.
// Opcode enum matches the 4-bit ctrl field from decode.
package alu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_ADDU  = 4'b0000,
        ALU_SUBU  = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_NOR   = 4'b0101,
        ALU_SLT   = 4'b0110,
        ALU_SLTU  = 4'b0111,
        ALU_MULT  = 4'b1000,
        ALU_MFHI  = 4'b1001,
        ALU_MULTU = 4'b1010,
        ALU_MFLO  = 4'b1011,
        ALU_SLL   = 4'b1100,
        ALU_SRL   = 4'b1101,
        ALU_SRA   = 4'b1110,
        ALU_LUI   = 4'b1111
    } alu_op_e;

    function automatic logic is_mul(alu_op_e op);
        return (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction

endpackage

// File: rtl/alu_hilo_regs.sv
// HI/LO product register pair.
// Async active-low clear, loaded whole on a multiply edge.
module alu_hilo_regs
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [2*WIDTH-1:0] d,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [2*WIDTH-1:0] hilo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hilo <= '0;
        end else if (we) begin
            hilo <= d;
        end
    end

    assign hi = hilo[2*WIDTH-1:WIDTH];
    assign lo = hilo[WIDTH-1:0];

endmodule

// File: rtl/alu_hilo.sv
// Execute-stage ALU: combinational result plus
// multiply writeback into the HI/LO pair.
module alu_hilo
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] out
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int HALF = WIDTH / 2;

    alu_op_e            op;
    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] sa;
    logic [2*WIDTH-1:0] sb;
    logic [2*WIDTH-1:0] ua;
    logic [2*WIDTH-1:0] ub;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               lt_s;
    logic               lt_u;

    assign op = alu_op_e'(ctrl);
    assign sh = a[SHW-1:0];

    // Extend to full product width so the low 2W bits are exact
    assign sa = {{WIDTH{a[WIDTH-1]}}, a};
    assign sb = {{WIDTH{b[WIDTH-1]}}, b};
    assign ua = {{WIDTH{1'b0}}, a};
    assign ub = {{WIDTH{1'b0}}, b};

    always_comb begin
        prod = '0;
        if (op == ALU_MULT) begin
            prod = sa * sb;
        end else begin
            prod = ua * ub;
        end
    end

    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    alu_hilo_regs #(
        .WIDTH (WIDTH)
    ) u_regs (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (is_mul(op)),
        .d     (prod),
        .hi    (hi),
        .lo    (lo)
    );

    always_comb begin
        out = '0;
        unique case (op)
            ALU_ADDU:  out = a + b;
            ALU_SUBU:  out = a - b;
            ALU_AND:   out = a & b;
            ALU_OR:    out = a | b;
            ALU_XOR:   out = a ^ b;
            ALU_NOR:   out = ~(a | b);
            ALU_SLT:   out = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SLTU:  out = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_MULT:  out = prod[WIDTH-1:0];
            ALU_MFHI:  out = hi;
            ALU_MULTU: out = prod[WIDTH-1:0];
            ALU_MFLO:  out = lo;
            ALU_SLL:   out = b << sh;
            ALU_SRL:   out = b >> sh;
            ALU_SRA:   out = $unsigned($signed(b) >>> sh);
            ALU_LUI:   out = {b[HALF-1:0], {HALF{1'b0}}};
            default:   out = '0;
        endcase
    end

endmodule

// File: tb/tb_alu_hilo.sv
// Directed bench for alu_hilo: vector table for the
// combinational ops plus hand-written HI/LO sequences.
module tb_alu_hilo;

    localparam logic [3:0] ADDU  = 4'b0000;
    localparam logic [3:0] SUBU  = 4'b0001;
    localparam logic [3:0] AND_  = 4'b0010;
    localparam logic [3:0] OR_   = 4'b0011;
    localparam logic [3:0] XOR_  = 4'b0100;
    localparam logic [3:0] NOR_  = 4'b0101;
    localparam logic [3:0] SLT   = 4'b0110;
    localparam logic [3:0] SLTU  = 4'b0111;
    localparam logic [3:0] MULT  = 4'b1000;
    localparam logic [3:0] MFHI  = 4'b1001;
    localparam logic [3:0] MULTU = 4'b1010;
    localparam logic [3:0] MFLO  = 4'b1011;
    localparam logic [3:0] SLL   = 4'b1100;
    localparam logic [3:0] SRL   = 4'b1101;
    localparam logic [3:0] SRA   = 4'b1110;
    localparam logic [3:0] LUI   = 4'b1111;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 16;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] out;

    int   n_tests;
    int   n_fail;
    vec_t vecs [NV];

    alu_hilo dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .ctrl  (ctrl),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] exp);
        n_tests++;
        if (out !== exp) begin
            n_fail++;
            $display("FAIL %s: out=%08h expected=%08h", name, out, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c,
                         input logic [31:0] va,
                         input logic [31:0] vb);
        ctrl = c;
        a    = va;
        b    = vb;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Multiply, check its own result, then read back HI and LO.
    task automatic mul_chk(input string name,
                           input logic [3:0] c,
                           input logic [31:0] va,
                           input logic [31:0] vb,
                           input logic [31:0] ehi,
                           input logic [31:0] elo);
        drive(c, va, vb);
        chk({name, ".out"}, elo);
        step();
        drive(MFHI, 32'h0, 32'h0);
        chk({name, ".hi"}, ehi);
        drive(MFLO, 32'h0, 32'h0);
        chk({name, ".lo"}, elo);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{"addu_wrap", ADDU, 32'hFFFFFFFF, 32'h1, 32'h0};
        vecs[1]  = '{"subu_wrap", SUBU, 32'h0, 32'h1, 32'hFFFFFFFF};
        vecs[2]  = '{"and", AND_, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200};
        vecs[3]  = '{"or", OR_, 32'hF0F0_0000, 32'h0F00_000F, 32'hFFF0_000F};
        vecs[4]  = '{"xor", XOR_, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555};
        vecs[5]  = '{"nor", NOR_, 32'hF0F0_0000, 32'h0F00_000F, 32'h000F_FFF0};
        vecs[6]  = '{"slt", SLT, 32'hFFFFFFFF, 32'h1, 32'h1};
        vecs[7]  = '{"sltu", SLTU, 32'hFFFFFFFF, 32'h1, 32'h0};
        vecs[8]  = '{"slt_ge", SLT, 32'h5, 32'h5, 32'h0};
        vecs[9]  = '{"sra", SRA, 32'h4, 32'h8000_0000, 32'hF800_0000};
        vecs[10] = '{"srl", SRL, 32'h4, 32'h8000_0000, 32'h0800_0000};
        vecs[11] = '{"lui", LUI, 32'h0, 32'h1234, 32'h1234_0000};
        vecs[12] = '{"sll", SLL, 32'h8, 32'h0000_00AB, 32'h0000_AB00};
        vecs[13] = '{"sll_hi_ign", SLL, 32'hFFFF_FFE1, 32'h1, 32'h2};
        vecs[14] = '{"srl_zero", SRL, 32'h20, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[15] = '{"sra_31", SRA, 32'h1F, 32'h8000_0000, 32'hFFFF_FFFF};

        rst_n = 1'b0;
        drive(MFHI, 32'h0, 32'h0);
        chk("reset.hi", 32'h0);
        drive(MFLO, 32'h0, 32'h0);
        chk("reset.lo", 32'h0);
        step();
        rst_n = 1'b1;
        step();

        mul_chk("multu_5x4", MULTU, 32'd5, 32'd4, 32'h0, 32'd20);
        mul_chk("multu_ffx2", MULTU, 32'hFFFFFFFF, 32'h2,
                32'h1, 32'hFFFFFFFE);
        mul_chk("multu_big", MULTU, 32'h7DD6B23D, 32'h2,
                32'h0, 32'hFBAD647A);
        mul_chk("mult_m4m3", MULT, 32'hFFFFFFFC, 32'hFFFFFFFD,
                32'h0, 32'd12);
        mul_chk("mult_m2113", MULT, 32'hFFFFF7BF, 32'h2,
                32'hFFFFFFFF, 32'hFFFFEF7E);
        mul_chk("mult_m1xbig", MULT, 32'hFFFFFFFF, 32'h7DD6B23D,
                32'hFFFFFFFF, 32'h82294DC3);
        mul_chk("multu_ffxff", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001);

        // Back-to-back multiplies: second overwrites both halves
        drive(MULT, 32'hFFFFFFFF, 32'h2);
        step();
        drive(MULTU, 32'd3, 32'd7);
        step();
        drive(MFHI, 32'h0, 32'h0);
        chk("b2b.hi", 32'h0);
        drive(MFLO, 32'h0, 32'h0);
        chk("b2b.lo", 32'd21);

        // Load a known pair, run the sweep with edges, recheck pair
        drive(MULTU, 32'h0001_0000, 32'h0001_0003);
        step();
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            chk(vecs[i].name, vecs[i].exp);
            step();
        end
        drive(MFHI, 32'h0, 32'h0);
        chk("sweep.hi_kept", 32'h1);
        drive(MFLO, 32'h0, 32'h0);
        chk("sweep.lo_kept", 32'h0003_0000);

        // Async reset mid-cycle, then a multiply edge under reset
        mul_chk("rst_load", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h00000001);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        drive(MFHI, 32'h0, 32'h0);
        chk("rst_async.hi", 32'h0);
        drive(MFLO, 32'h0, 32'h0);
        chk("rst_async.lo", 32'h0);
        drive(MULT, 32'd3, 32'd3);
        chk("rst_mult.out", 32'd9);
        step();
        drive(MFLO, 32'h0, 32'h0);
        chk("rst_nowrite.lo", 32'h0);
        rst_n = 1'b1;
        step();
        chk("rst_release.lo", 32'h0);
        drive(MFHI, 32'h0, 32'h0);
        chk("rst_release.hi", 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_hilo.md
Name: alu_hilo

Overview:
- 32-bit MIPS-style ALU with a 64-bit HI/LO multiply result register pair.
- Arithmetic, logic, compare and shift results are combinational.
- Multiply operations also load HI/LO on the clock edge; later move-from operations read them back.
- Sits in the execute stage of the single-issue datapath.

Parameters:
- WIDTH, 32, data path width. HI/LO are each WIDTH bits, and the product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; HI/LO update on the rising edge.
- rst_n  input  1  asynchronous active-low reset; clears HI/LO.
- a  input  32  operand A (shift amount source for shifts: a[4:0]).
- b  input  32  operand B (the value that is shifted for shifts).
- ctrl  input  4  operation select.
- out  output  32  result, combinational from a, b, ctrl, HI, LO.

Behaviour:
- Reset: the rst_n falling edge clears HI and LO to 0 immediately, independent of clk.
  - While rst_n=0, HI/LO hold 0 and no multiply write occurs.
  - out stays combinational during reset (MFHI/MFLO return 0).
- ctrl encoding; all arithmetic is modulo 2^32 with no overflow trap:
  - 0000 ADDU: out = a+b.
  - 0001 SUBU: out = a-b.
  - 0010 AND. 0011 OR. 0100 XOR. 0101 NOR: out = ~(a|b).
  - 0110 SLT: out = 1 if $signed(a) < $signed(b), else 0.
  - 0111 SLTU: unsigned compare, same 0/1 output as SLT.
  - 1000 MULT: P = signed(a) × signed(b), full 64 bits. out = P[31:0]. At posedge clk, HI <= P[63:32] and LO <= P[31:0].
  - 1001 MFHI: out = HI. No register change.
  - 1010 MULTU: as MULT but with an unsigned product.
  - 1011 MFLO: out = LO. No register change.
  - 1100 SLL: out = b << a[4:0].
  - 1101 SRL: out = b >> a[4:0], logical.
  - 1110 SRA: out = b >>> a[4:0], arithmetic.
  - 1111 LUI: out = {b[15:0], 16'h0}.
- Latency:
  - All out values are 0-cycle combinational.
  - HI/LO become visible via MFHI/MFLO from the cycle after the multiply edge.
  - Back-to-back MULT then MFHI returns the new product.
- HI/LO hold their value on every non-multiply op.
- Consecutive multiplies: each edge with a multiply ctrl overwrites both halves.
- Sign rules:
  - MULT sign-extends both operands to 64 bits before multiplying.
  - MULTU zero-extends both operands.
- Shifts with a[4:0]=0 pass b unchanged. Upper bits a[31:5] are ignored.
- No X propagation from unused codes: all 16 codes are defined.
- A single-cycle multiply is acceptable (a synthesised multiplier). No multi-cycle handshake exists.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum with the 16 ctrl codes: ALU_ADDU … ALU_LUI, ALU_MULT=4'b1000, ALU_MFHI, ALU_MULTU, ALU_MFLO.
  - WIDTH constant.
- One natural sub-module, alu_hilo_regs:
  - 64-bit HI/LO register with async active-low clear and write-enable.
  - Fed by the multiplier result; the multiplier itself stays in the top.

Test Plan:
- MULTU a=5, b=4, then MFLO next cycle:
  - multiply cycle out=20; MFLO out=20; HI=0.
- MULTU a=0xFFFFFFFF, b=2, then MFHI → 1. A following MFLO → 0xFFFFFFFE.
- MULTU a=2111222333 (0x7DD6B23D), b=2, then MFLO → 0xFBAD647A; MFHI → 0.
- MULT signed cases:
  - a=-4, b=-3, then MFLO → 12; MFHI → 0.
  - a=-2113, b=2 → LO=0xFFFFEF7E, HI=0xFFFFFFFF.
  - a=0xFFFFFFFF, b=2111222333 → LO=0x82294DC3, HI=0xFFFFFFFF.
- Reset:
  - Load HI/LO via MULTU 0xFFFFFFFF × 0xFFFFFFFF.
  - Pulse rst_n low mid-cycle (not on a clock edge) → MFHI and MFLO both return 0 immediately.
  - A MULT edge while rst_n=0 does not write.
- Combinational ops sweep:
  - ADDU 0xFFFFFFFF+1 → 0.
  - SUBU 0-1 → 0xFFFFFFFF.
  - SLT -1<1 → 1; SLTU 0xFFFFFFFF<1 → 0.
  - SRA b=0x80000000, a=4 → 0xF8000000.
  - SRL with the same operands → 0x08000000.
  - LUI b=0x1234 → 0x12340000.
  - HI/LO remain unchanged throughout the sweep.
